// File: rtl/mem_loader.sv
// mem_loader: byte-stream boot loader for an instruction/data memory.
//
// Collects a stream of bytes, packs every four into a big-endian 32-bit
// word and writes it into the target memory at consecutive word addresses.
// A byte flagged as last that completes a word finishes the load and
// releases the processor. A stream that ends mid-word or overflows the
// memory aborts the load. The design stays in DONE or ERROR until the next
// reset.
//
// Ports
//   clock       sole clock, rising edge
//   reset       synchronous, active-high
//   in_valid    byte on in_data is valid
//   in_data     load-stream byte
//   in_last     in_data is the final byte of the image
//   in_ready    loader accepts a byte this cycle
//   mem_we      one-cycle memory write strobe
//   mem_addr    word address of the write
//   mem_wdata   assembled word, bit 0 = MSB
//   word_count  words written so far
//   core_run    high releases the processor from reset
//   done        image loaded successfully
//   error       load failed (sticky until reset)
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_LOAD  | accepting bytes, assembling the current word
// ST_WRITE | single cycle: strobe the assembled word into memory
// ST_DONE  | image complete, processor running, input ignored
// ST_ERROR | truncated word or overflow, processor held, input ignored

module mem_loader #(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 1024
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [0:31]       mem_wdata,
   output logic [ADDR_W:0]   word_count,
   output logic              core_run,
   output logic              done,
   output logic              error
);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_e;

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W + 1)'(MAX_WORDS);
   localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [0:23]       partial_q, partial_d;
   logic [0:31]       wdata_q, wdata_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              last_q, last_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_LOAD;
         byte_idx_q <= 2'd0;
         partial_q  <= '0;
         wdata_q    <= '0;
         count_q    <= '0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         partial_q  <= partial_d;
         wdata_q    <= wdata_d;
         count_q    <= count_d;
         last_q     <= last_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      partial_d  = partial_q;
      wdata_d    = wdata_q;
      count_d    = count_q;
      last_d     = last_q;

      // Outputs are gated by reset so that a write pending in the same
      // cycle as reset never reaches the memory.
      in_ready   = reset;
      mem_we     = 1'b0;
      core_run   = 1'b0;
      done       = 1'b0;
      error      = 1'b0;
      mem_addr   = count_q[ADDR_W-1:0];
      mem_wdata  = wdata_q;
      word_count = count_q;

      unique case (state_q)
         ST_LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (count_q == MAX_CNT) begin
                  // Memory already full: the byte is swallowed and the
                  // load aborts without touching the memory.
                  state_d = ST_ERROR;
               end else begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  unique case (byte_idx_q)
                     2'd0: partial_d[0:7]   = in_data;
                     2'd1: partial_d[8:15]  = in_data;
                     2'd2: partial_d[16:23] = in_data;
                     default: begin
                        // The output word register only changes here, so
                        // mem_wdata holds steady outside the write.
                        wdata_d = {partial_q, in_data};
                        last_d  = in_last;
                        state_d = ST_WRITE;
                     end
                  endcase
                  if (in_last && (byte_idx_q != 2'd3)) begin
                     state_d = ST_ERROR;
                  end
               end
            end
         end

         ST_WRITE: begin
            mem_we  = ~reset;
            count_d = count_q + CNT_ONE;
            state_d = last_q ? ST_DONE : ST_LOAD;
         end

         ST_DONE: begin
            done     = ~reset;
            core_run = ~reset;
         end

         default: begin
            error = ~reset;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_loader.sv
// Testbench for mem_loader. Two instances: a full-size loader and a
// two-word loader for the overflow scenario. Writes and byte acceptances
// are logged by a negedge monitor and compared against expectations
// derived from the byte streams the bench generates.

module tb_mem_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic        in_valid = 1'b0;
   logic [7:0]  in_data  = 8'h00;
   logic        in_last  = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [0:31] mem_wdata;
   logic [10:0] word_count;
   logic        core_run;
   logic        done;
   logic        error;

   logic        s_in_valid = 1'b0;
   logic [7:0]  s_in_data  = 8'h00;
   logic        s_in_last  = 1'b0;
   logic        s_in_ready;
   logic        s_mem_we;
   logic [3:0]  s_mem_addr;
   logic [0:31] s_mem_wdata;
   logic [4:0]  s_word_count;
   logic        s_core_run;
   logic        s_done;
   logic        s_error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int both_cnt = 0;

   int          wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          s_wr_addr_q[$];
   logic [31:0] s_wr_data_q[$];
   int          acc_cyc_q[$];

   mem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .word_count(word_count),
      .core_run(core_run), .done(done), .error(error)
   );

   mem_loader #(.ADDR_W(4), .MAX_WORDS(2)) dut_small (
      .clock(clock), .reset(reset),
      .in_valid(s_in_valid), .in_data(s_in_data), .in_last(s_in_last),
      .in_ready(s_in_ready), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
      .mem_wdata(s_mem_wdata), .word_count(s_word_count),
      .core_run(s_core_run), .done(s_done), .error(s_error)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   always @(negedge clock) begin
      if (mem_we) begin
         wr_addr_q.push_back(int'(mem_addr));
         wr_data_q.push_back(mem_wdata);
      end
      if (s_mem_we) begin
         s_wr_addr_q.push_back(int'(s_mem_addr));
         s_wr_data_q.push_back(s_mem_wdata);
      end
      if (in_valid && in_ready && !reset) acc_cyc_q.push_back(cyc);
      if ((done && error) || (s_done && s_error)) both_cnt++;
   end

   function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [7:0] b2, input logic [7:0] b3);
      return {b0, b1, b2, b3};
   endfunction

   task automatic clear_logs();
      wr_addr_q.delete();
      wr_data_q.delete();
      s_wr_addr_q.delete();
      s_wr_data_q.delete();
      acc_cyc_q.delete();
   endtask

   task automatic apply_reset();
      in_valid = 1'b0; in_last = 1'b0;
      s_in_valid = 1'b0; s_in_last = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      clear_logs();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Presents one byte and waits for it to be taken. Returns at 1 time unit
   // after the accepting edge.
   task automatic send_byte(input bit sel, input logic [7:0] b, input bit l, input int gap);
      bit ok;
      bit rdy;
      idle(gap);
      if (sel) begin s_in_valid = 1'b1; s_in_data = b; s_in_last = l; end
      else     begin in_valid   = 1'b1; in_data   = b; in_last   = l; end
      ok = 1'b0;
      for (int n = 0; n < 20 && !ok; n++) begin
         @(negedge clock);
         rdy = sel ? s_in_ready : in_ready;
         @(posedge clock);
         #1;
         ok = rdy;
      end
      if (sel) begin s_in_valid = 1'b0; s_in_last = 1'b0; end
      else     begin in_valid   = 1'b0; in_last   = 1'b0; end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL send_accept byte=%h got=not_accepted exp=accepted", b);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
      s_in_valid = 1'b1; s_in_data = 8'hFF; s_in_last = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
      total++; if (core_run !== 1'b0) begin bad++; $display("FAIL rst_core_run got=%b exp=0", core_run); end
      total++; if (done !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL rst_flags got=%b%b exp=00", done, error); end
      total++; if (word_count !== 11'd0) begin bad++; $display("FAIL rst_word_count got=%0d exp=0", word_count); end
      total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", mem_wdata); end
      in_valid = 1'b0; in_last = 1'b0; s_in_valid = 1'b0;
      reset = 1'b0;
      clear_logs();
      idle(3);
      total++; if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b%b exp=11", in_ready, s_in_ready); end
      total++; if (wr_addr_q.size() != 0) begin bad++; $display("FAIL post_rst_writes got=%0d exp=0", wr_addr_q.size()); end
   endtask

   task automatic test_two_words();
      logic [7:0] b[8];
      b = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      apply_reset();
      for (int i = 0; i < 8; i++) send_byte(1'b0, b[i], i == 7, 0);
      idle(2);
      total++; if (wr_addr_q.size() != 2) begin bad++; $display("FAIL two_nwrites got=%0d exp=2", wr_addr_q.size()); end
      if (wr_addr_q.size() == 2) begin
         total++; if (wr_addr_q[0] != 0 || wr_data_q[0] !== 32'h12345678) begin bad++; $display("FAIL two_w0 got=%0d:%h exp=0:12345678", wr_addr_q[0], wr_data_q[0]); end
         total++; if (wr_addr_q[1] != 1 || wr_data_q[1] !== 32'h9ABCDEF0) begin bad++; $display("FAIL two_w1 got=%0d:%h exp=1:9abcdef0", wr_addr_q[1], wr_data_q[1]); end
      end
      total++; if (word_count !== 11'd2) begin bad++; $display("FAIL two_count got=%0d exp=2", word_count); end
      total++; if (done !== 1'b1 || core_run !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL two_status got=d%b r%b e%b exp=d1 r1 e0", done, core_run, error); end
      in_valid = 1'b1; in_data = 8'h55;
      idle(4);
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b0 || wr_addr_q.size() != 2 || done !== 1'b1) begin bad++; $display("FAIL two_done_hold got=rdy%b n%0d d%b exp=rdy0 n2 d1", in_ready, wr_addr_q.size(), done); end
   endtask

   task automatic test_single_word();
      apply_reset();
      send_byte(1'b0, 8'h44, 1'b0, 0);
      send_byte(1'b0, 8'h00, 1'b0, 0);
      send_byte(1'b0, 8'h03, 1'b0, 0);
      in_valid = 1'b1;
      send_byte(1'b0, 8'h00, 1'b1, 0);
      in_valid = 1'b1;
      total++; if (in_ready !== 1'b0 || mem_we !== 1'b1) begin bad++; $display("FAIL single_write_cycle got=rdy%b we%b exp=rdy0 we1", in_ready, mem_we); end
      total++; if (mem_addr !== 10'd0 || mem_wdata !== 32'h44000300) begin bad++; $display("FAIL single_word got=%0d:%h exp=0:44000300", mem_addr, mem_wdata); end
      idle(1);
      total++; if (mem_we !== 1'b0 || done !== 1'b1 || core_run !== 1'b1) begin bad++; $display("FAIL single_done got=we%b d%b r%b exp=we0 d1 r1", mem_we, done, core_run); end
      idle(3);
      in_valid = 1'b0;
      total++; if (wr_addr_q.size() != 1 || mem_wdata !== 32'h44000300) begin bad++; $display("FAIL single_hold got=n%0d %h exp=n1 44000300", wr_addr_q.size(), mem_wdata); end
   endtask

   task automatic test_error_partial();
      apply_reset();
      send_byte(1'b0, 8'hAA, 1'b0, 0);
      send_byte(1'b0, 8'hBB, 1'b0, 1);
      send_byte(1'b0, 8'hCC, 1'b1, 0);
      total++; if (error !== 1'b1 || core_run !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL partial_status got=e%b r%b d%b exp=e1 r0 d0", error, core_run, done); end
      in_valid = 1'b1; in_data = 8'hDD; in_last = 1'b1;
      idle(5);
      in_valid = 1'b0; in_last = 1'b0;
      total++; if (wr_addr_q.size() != 0 || word_count !== 11'd0) begin bad++; $display("FAIL partial_nowrite got=n%0d wc%0d exp=n0 wc0", wr_addr_q.size(), word_count); end
      total++; if (in_ready !== 1'b0 || error !== 1'b1) begin bad++; $display("FAIL partial_hold got=rdy%b e%b exp=rdy0 e1", in_ready, error); end
      apply_reset();
      total++; if (error !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL error_reset got=e%b rdy%b exp=e0 rdy1", error, in_ready); end
   endtask

   task automatic test_max_words();
      logic [7:0] b[9];
      for (int i = 0; i < 9; i++) b[i] = 8'($urandom);
      apply_reset();
      for (int i = 0; i < 9; i++) send_byte(1'b1, b[i], 1'b0, 0);
      total++; if (s_error !== 1'b1 || s_done !== 1'b0 || s_core_run !== 1'b0) begin bad++; $display("FAIL max_status got=e%b d%b exp=e1 d0", s_error, s_done); end
      total++; if (s_wr_addr_q.size() != 2) begin bad++; $display("FAIL max_nwrites got=%0d exp=2", s_wr_addr_q.size()); end
      if (s_wr_addr_q.size() == 2) begin
         total++; if (s_wr_addr_q[0] != 0 || s_wr_data_q[0] !== pack(b[0], b[1], b[2], b[3])) begin bad++; $display("FAIL max_w0 got=%0d:%h exp=0:%h", s_wr_addr_q[0], s_wr_data_q[0], pack(b[0], b[1], b[2], b[3])); end
         total++; if (s_wr_addr_q[1] != 1 || s_wr_data_q[1] !== pack(b[4], b[5], b[6], b[7])) begin bad++; $display("FAIL max_w1 got=%0d:%h exp=1:%h", s_wr_addr_q[1], s_wr_data_q[1], pack(b[4], b[5], b[6], b[7])); end
      end
      s_in_valid = 1'b1;
      idle(4);
      s_in_valid = 1'b0;
      total++; if (s_word_count !== 5'd2 || s_wr_addr_q.size() != 2) begin bad++; $display("FAIL max_count got=wc%0d n%0d exp=wc2 n2", s_word_count, s_wr_addr_q.size()); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 4; i++) send_byte(1'b0, 8'(8'h10 + i), 1'b0, 0);
      for (int i = 0; i < 3; i++) send_byte(1'b0, 8'(8'h20 + i), 1'b0, 0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      total++; if (wr_addr_q.size() != 1 || word_count !== 11'd0) begin bad++; $display("FAIL mid_reset got=n%0d wc%0d exp=n1 wc0", wr_addr_q.size(), word_count); end
      clear_logs();
      for (int i = 0; i < 4; i++) send_byte(1'b0, 8'(8'h30 + i), 1'b0, 0);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      total++; if (wr_addr_q.size() != 0 || word_count !== 11'd0) begin bad++; $display("FAIL write_reset got=n%0d wc%0d exp=n0 wc0", wr_addr_q.size(), word_count); end
      for (int i = 0; i < 4; i++) send_byte(1'b0, 8'(8'hA0 + i), i == 3, 0);
      idle(2);
      total++; if (wr_addr_q.size() != 1) begin bad++; $display("FAIL fresh_nwrites got=%0d exp=1", wr_addr_q.size()); end
      if (wr_addr_q.size() == 1) begin
         total++; if (wr_addr_q[0] != 0 || wr_data_q[0] !== 32'hA0A1A2A3) begin bad++; $display("FAIL fresh_word got=%0d:%h exp=0:a0a1a2a3", wr_addr_q[0], wr_data_q[0]); end
      end
      total++; if (done !== 1'b1 || word_count !== 11'd1) begin bad++; $display("FAIL fresh_done got=d%b wc%0d exp=d1 wc1", done, word_count); end
   endtask

   task automatic test_random();
      logic [7:0] b[64];
      int slow;
      for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
      apply_reset();
      for (int i = 0; i < 64; i++) begin
         send_byte(1'b0, b[i], i == 63, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
      idle(2);
      total++; if (wr_addr_q.size() != 16) begin bad++; $display("FAIL rand_nwrites got=%0d exp=16", wr_addr_q.size()); end
      for (int w = 0; w < 16 && w < wr_addr_q.size(); w++) begin
         total++;
         if (wr_addr_q[w] != w || wr_data_q[w] !== pack(b[4*w], b[4*w+1], b[4*w+2], b[4*w+3])) begin
            bad++;
            $display("FAIL rand_word%0d got=%0d:%h exp=%0d:%h", w, wr_addr_q[w], wr_data_q[w], w, pack(b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]));
         end
      end
      total++; if (done !== 1'b1 || word_count !== 11'd16) begin bad++; $display("FAIL rand_done got=d%b wc%0d exp=d1 wc16", done, word_count); end
      slow = 0;
      for (int i = 0; i + 4 < acc_cyc_q.size(); i++) begin
         if (acc_cyc_q[i+4] - acc_cyc_q[i] < 5) slow++;
      end
      total++; if (acc_cyc_q.size() != 64 || slow != 0) begin bad++; $display("FAIL rand_throughput got=acc%0d viol%0d exp=acc64 viol0", acc_cyc_q.size(), slow); end
   endtask

   initial begin
      test_reset();
      test_two_words();
      test_single_word();
      test_error_partial();
      test_max_words();
      test_reset_mid();
      test_random();
      total++; if (both_cnt != 0) begin bad++; $display("FAIL done_and_error got=%0d exp=0", both_cnt); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
